// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receive path: parity modes,
// receiver states and the oversampling divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Clocks per oversampling tick, rounded to nearest: round(clk_hz / (baud * 16)).
    function automatic int os_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud * 8) / (baud * 16));
    endfunction

endpackage

// File: rtl/uart_rx_param_fifo.sv
// Small synchronous FIFO holding received entries; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_lastOut;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    // When empty the head shows the most recently popped entry rather than a stale slot.
    assign o_data = o_empty ? r_lastOut : r_mem[r_rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_lastOut <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_lastOut <= r_mem[r_rdPtr];
                r_rdPtr   <= r_rdPtr + PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling with a 3-sample majority vote,
// optional parity, 1 or 2 stop bits, and an output FIFO with valid/ready.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK100MHZ,
    input  logic                 ck_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OS_DIV = os_div(CLK_HZ, BAUD);
    localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int EW     = DATA_BITS + 2;
    localparam logic [CW-1:0] OS_LAST   = CW'(OS_DIV - 1);
    localparam logic [CW-1:0] OS_ONE    = CW'(1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

    rx_state_t r_state;
    rx_state_t w_nextState;

    logic                 r_rxMeta;
    logic                 r_rxSync;
    logic                 r_rxPrev;
    logic [CW-1:0]        r_osCnt;
    logic [3:0]           r_tickCnt;
    logic [3:0]           r_bitCnt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parAcc;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_push;
    logic [EW-1:0]        r_pushEntry;
    logic                 r_overrun;

    logic          w_tick;
    logic          w_fall;
    logic          w_midTick;
    logic          w_endTick;
    logic          w_maj;
    logic          w_lastData;
    logic          w_lastStop;
    logic          w_stopErr;
    logic          w_parErr;
    logic [EW-1:0] w_head;
    logic          w_full;
    logic          w_empty;

    assign w_tick     = (r_state != ST_IDLE) && (r_osCnt == OS_LAST);
    assign w_fall     = r_rxPrev & ~r_rxSync;
    assign w_midTick  = w_tick && (r_tickCnt == 4'd9);
    assign w_endTick  = w_tick && (r_tickCnt == 4'd15);
    assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rxSync) | (r_samp[1] & r_rxSync);
    assign w_lastData = (r_bitCnt == LAST_DATA);
    assign w_lastStop = (r_bitCnt == LAST_STOP);
    assign w_stopErr  = r_ferr | ~w_maj;
    assign w_parErr   = r_parAcc ^ w_maj ^ ODD_PAR;

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bits are resolved at tick 9; state advances at the bit boundary except when
    // the frame ends, where leaving mid stop bit gives margin for the next start edge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_nextState = ST_START;
            end
            ST_START: begin
                if (w_midTick && w_maj) w_nextState = ST_IDLE;
                else if (w_endTick)     w_nextState = ST_DATA;
            end
            ST_DATA: begin
                if (w_endTick && w_lastData)
                    w_nextState = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_endTick) w_nextState = ST_STOP;
            end
            ST_STOP: begin
                if (w_midTick && w_lastStop)
                    w_nextState = w_stopErr ? ST_WAIT_HIGH : ST_IDLE;
            end
            ST_WAIT_HIGH: begin
                if (r_rxSync) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_rxMeta    <= 1'b1;
            r_rxSync    <= 1'b1;
            r_rxPrev    <= 1'b1;
            r_osCnt     <= '0;
            r_tickCnt   <= '0;
            r_bitCnt    <= '0;
            r_samp      <= '0;
            r_shift     <= '0;
            r_parAcc    <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_pushEntry <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_rxMeta  <= rx;
            r_rxSync  <= r_rxMeta;
            r_rxPrev  <= r_rxSync;
            r_push    <= 1'b0;
            r_overrun <= r_push & w_full & ~m_ready;
            if (r_state == ST_IDLE) begin
                r_osCnt   <= '0;
                r_tickCnt <= '0;
                r_bitCnt  <= '0;
                r_parAcc  <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end else begin
                r_osCnt <= w_tick ? '0 : r_osCnt + OS_ONE;
                if (w_tick) begin
                    r_tickCnt <= r_tickCnt + 4'd1;
                    if (r_tickCnt == 4'd7) r_samp[0] <= r_rxSync;
                    if (r_tickCnt == 4'd8) r_samp[1] <= r_rxSync;
                end
                if (w_endTick) begin
                    r_bitCnt <= (w_nextState != r_state) ? 4'd0 : r_bitCnt + 4'd1;
                end
                if (w_midTick) begin
                    case (r_state)
                        ST_DATA: begin
                            r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
                            r_parAcc <= r_parAcc ^ w_maj;
                        end
                        ST_PARITY: r_perr <= w_parErr;
                        ST_STOP: begin
                            r_ferr <= w_stopErr;
                            if (w_lastStop) begin
                                r_push      <= 1'b1;
                                r_pushEntry <= {r_shift, r_perr, w_stopErr};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK100MHZ),
        .rst_n  (ck_rst),
        .i_push (r_push),
        .i_data (r_pushEntry),
        .i_pop  (m_ready),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    assign m_data  = w_head[EW-1:2];
    assign m_perr  = w_head[1];
    assign m_ferr  = w_head[0];
    assign m_valid = ~w_empty;
    assign overrun = r_overrun;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed/randomised bench for uart_rx_param: three receivers (no parity,
// even parity, odd parity with two stop bits) checked against a frame-level model.
module tb_uart_rx_param;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int DEPTH  = 4;
    // round(100 MHz / 16 MHz) = 6 clocks per tick, 16 ticks per bit
    localparam int BIT_CLKS   = 96;
    localparam int FRAME_WAIT = 14 * BIT_CLKS;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } entry_t;

    logic       clk  = 1'b0;
    logic       rstN = 1'b0;
    logic [2:0] rxL  = 3'b111;
    logic [2:0] rdyL = 3'b000;
    logic [7:0] mData [3];
    logic [2:0] perrL;
    logic [2:0] ferrL;
    logic [2:0] validL;
    logic [2:0] ovL;
    logic [2:0] busyL;

    int     vectors     = 0;
    int     miscompares = 0;
    int     ovCnt [3];
    entry_t expQ [$];
    int     modelOcc    = 0;
    int     expOverrun  = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutNone (
        .CLK100MHZ(clk), .ck_rst(rstN), .rx(rxL[0]), .m_data(mData[0]),
        .m_perr(perrL[0]), .m_ferr(ferrL[0]), .m_valid(validL[0]),
        .m_ready(rdyL[0]), .overrun(ovL[0]), .busy(busyL[0]));

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutEven (
        .CLK100MHZ(clk), .ck_rst(rstN), .rx(rxL[1]), .m_data(mData[1]),
        .m_perr(perrL[1]), .m_ferr(ferrL[1]), .m_valid(validL[1]),
        .m_ready(rdyL[1]), .overrun(ovL[1]), .busy(busyL[1]));

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dutOdd (
        .CLK100MHZ(clk), .ck_rst(rstN), .rx(rxL[2]), .m_data(mData[2]),
        .m_perr(perrL[2]), .m_ferr(ferrL[2]), .m_valid(validL[2]),
        .m_ready(rdyL[2]), .overrun(ovL[2]), .busy(busyL[2]));

    // Overrun is a one-cycle pulse; tally pulses per receiver.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovL[i]) ovCnt[i]++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveBit(input int sel, input logic b);
        rxL[sel] = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Sends one frame and records what the receiver should deliver: sel 0 has
    // no parity, sel 1 even parity, sel 2 odd parity with two stop bits.
    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic pbit,
                                 input logic stopVal);
        entry_t e;
        int     ones;
        ones   = $countones(data) + int'(pbit);
        e.data = data;
        e.perr = (sel == 1) ? ((ones % 2) != 0) : (sel == 2) ? ((ones % 2) != 1) : 1'b0;
        e.ferr = ~stopVal;
        if (modelOcc < DEPTH) begin
            expQ.push_back(e);
            modelOcc++;
        end else begin
            expOverrun++;
        end
        driveBit(sel, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(sel, data[i]);
        if (sel != 0) driveBit(sel, pbit);
        driveBit(sel, stopVal);
        if (sel == 2) driveBit(sel, stopVal);
    endtask

    // Waits (bounded) for the head entry, compares it with the model, then pops it.
    task automatic checkEntry(input int sel, input string tag);
        int     waited;
        entry_t e;
        waited = 0;
        while (!validL[sel] && waited < FRAME_WAIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "-valid"}, 32'(validL[sel]), 1);
        if (validL[sel]) begin
            if (expQ.size() == 0) begin
                checkOutput({tag, "-spurious"}, 32'(validL[sel]), 0);
            end else begin
                e = expQ.pop_front();
                modelOcc--;
                checkOutput({tag, "-data"}, 32'(mData[sel]), 32'(e.data));
                checkOutput({tag, "-perr"}, 32'(perrL[sel]), 32'(e.perr));
                checkOutput({tag, "-ferr"}, 32'(ferrL[sel]), 32'(e.ferr));
            end
            if (rdyL[sel]) begin
                @(negedge clk);
            end else begin
                rdyL[sel] = 1'b1;
                @(negedge clk);
                rdyL[sel] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        int         ovBase;

        // Reset values
        repeat (5) @(negedge clk);
        checkOutput("rst-data", 32'(mData[0]), 0);
        checkOutput("rst-perr", 32'(perrL[0]), 0);
        checkOutput("rst-ferr", 32'(ferrL[0]), 0);
        checkOutput("rst-valid", 32'(validL), 0);
        checkOutput("rst-overrun", 32'(ovL), 0);
        checkOutput("rst-busy", 32'(busyL), 0);
        rstN = 1'b1;
        repeat (10) @(negedge clk);

        // Back-to-back frames with the consumer always ready
        rdyL[0] = 1'b1;
        fork
            begin
                applyStimulus(0, 8'h31, 1'b0, 1'b1);
                applyStimulus(0, 8'h32, 1'b0, 1'b1);
            end
            begin
                checkEntry(0, "b2b-first");
                checkEntry(0, "b2b-second");
            end
        join
        rdyL[0] = 1'b0;

        repeat (6) begin
            d = 8'($urandom);
            applyStimulus(0, d, 1'b0, 1'b1);
            checkEntry(0, "rand-none");
        end

        // Framing error followed by a held-low line (break)
        d = 8'($urandom);
        applyStimulus(0, d, 1'b0, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge clk);
        checkOutput("brk-busy", 32'(busyL[0]), 1);
        checkEntry(0, "brk-entry");
        checkOutput("brk-nopush", 32'(validL[0]), 0);
        rxL[0] = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        checkOutput("brk-idle", 32'(busyL[0]), 0);
        d = 8'($urandom);
        applyStimulus(0, d, 1'b0, 1'b1);
        checkEntry(0, "post-brk");

        // Parity checking, even then odd
        applyStimulus(1, 8'h31, 1'b1, 1'b1);
        checkEntry(1, "even-good");
        applyStimulus(1, 8'h31, 1'b0, 1'b1);
        checkEntry(1, "even-bad");
        applyStimulus(2, 8'h31, 1'b1, 1'b1);
        checkEntry(2, "odd-pbit1");
        applyStimulus(2, 8'h31, 1'b0, 1'b1);
        checkEntry(2, "odd-pbit0");
        repeat (3) begin
            d = 8'($urandom);
            applyStimulus(1, d, 1'($urandom), 1'b1);
            checkEntry(1, "rand-even");
            d = 8'($urandom);
            applyStimulus(2, d, 1'($urandom), 1'b1);
            checkEntry(2, "rand-odd");
        end

        // Overrun: one frame more than the FIFO holds, consumer stalled
        ovBase     = ovCnt[0];
        expOverrun = 0;
        repeat (DEPTH + 1) begin
            d = 8'($urandom);
            applyStimulus(0, d, 1'b0, 1'b1);
        end
        repeat (BIT_CLKS) @(negedge clk);
        checkOutput("ovr-pulses", 32'(ovCnt[0] - ovBase), 32'(expOverrun));
        repeat (DEPTH) checkEntry(0, "ovr-entry");
        checkOutput("ovr-drained", 32'(validL[0]), 0);

        // Short glitch is rejected as a false start
        rxL[0] = 1'b0;
        repeat (20) @(negedge clk);
        rxL[0] = 1'b1;
        checkOutput("glitch-busy", 32'(busyL[0]), 1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("glitch-idle", 32'(busyL[0]), 0);
        checkOutput("glitch-nopush", 32'(validL[0]), 0);

        // Reset mid-frame with an entry already queued
        d = 8'($urandom);
        applyStimulus(0, d, 1'b0, 1'b1);
        d = 8'($urandom);
        driveBit(0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(0, d[i]);
        rstN   = 1'b0;
        rxL[0] = 1'b1;
        expQ.delete();
        modelOcc = 0;
        #2;
        checkOutput("mid-rst-data", 32'(mData[0]), 0);
        checkOutput("mid-rst-flags", 32'({perrL[0], ferrL[0]}), 0);
        checkOutput("mid-rst-valid", 32'(validL[0]), 0);
        checkOutput("mid-rst-busy", 32'(busyL[0]), 0);
        checkOutput("mid-rst-overrun", 32'(ovL[0]), 0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        checkOutput("post-rst-nopush", 32'(validL[0]), 0);
        d = 8'($urandom);
        applyStimulus(0, d, 1'b0, 1'b1);
        checkEntry(0, "post-rst");
        checkOutput("post-rst-empty", 32'(validL[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
